// File: rtl/word_array_ctrl.sv
// Sequencer for an array of NAND-latch word cells. It runs one read or write at a time and
// frames each select pulse with a setup cycle before it and a hold cycle after it.
module word_array_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned NUM_WORDS = 6,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 arr_op,
  output logic [NUM_WORDS-1:0] arr_sel,
  output logic [DATA_W-1:0]    arr_in_bus,
  input  logic [DATA_W-1:0]    arr_out_bus
);

  localparam int unsigned CntW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(PULSE_CYC - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StAccess = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 write_q, write_d;
  logic                 hit_q, hit_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 req_ready_d, rsp_valid_d, rsp_err_d, arr_op_d;
  logic [DATA_W-1:0]    rsp_rdata_d, arr_in_bus_d;
  logic [NUM_WORDS-1:0] arr_sel_d, sel_onehot;
  logic                 req_hit;

  assign req_hit = (32'(req_addr) < NUM_WORDS);

  // Out-of-range requests keep hit_q low, so no select line is ever raised for them.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      sel_onehot[i] = hit_q && (32'(addr_q) == i);
    end
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    hit_d        = hit_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready;
    rsp_valid_d  = rsp_valid;
    rsp_err_d    = rsp_err;
    rsp_rdata_d  = rsp_rdata;
    arr_op_d     = arr_op;
    arr_sel_d    = arr_sel;
    arr_in_bus_d = arr_in_bus;
    case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          state_d      = StSetup;
          write_d      = req_write;
          addr_d       = req_addr;
          hit_d        = req_hit;
          req_ready_d  = 1'b0;
          arr_op_d     = req_write && req_hit;
          arr_in_bus_d = (req_write && req_hit) ? req_wdata : '0;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        cnt_d     = CntReload;
        arr_sel_d = sel_onehot;
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d     = StHold;
          arr_sel_d   = '0;
          rsp_rdata_d = (!write_q && hit_q) ? arr_out_bus : '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        state_d      = StResp;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = !hit_q;
        arr_op_d     = 1'b0;
        arr_in_bus_d = '0;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d      = StIdle;
        req_ready_d  = 1'b1;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        arr_op_d     = 1'b0;
        arr_sel_d    = '0;
        arr_in_bus_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      arr_op     <= 1'b0;
      arr_sel    <= '0;
      arr_in_bus <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      hit_q      <= hit_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rsp_rdata_d;
      arr_op     <= arr_op_d;
      arr_sel    <= arr_sel_d;
      arr_in_bus <= arr_in_bus_d;
    end
  end

endmodule
